// File: rtl/test_pkt_pkg.sv
// Shared types and constants for the PairHMM packet test harness.
package test_pkt_pkg;

  localparam int READ_LEN    = 6;
  localparam int HAP_LEN     = 8;
  localparam int DEF_MATCH_W = 1;
  localparam int CALC_LEN    = READ_LEN + HAP_LEN - 1;

  // Feedback mask for the shift-right Fibonacci form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef logic [1:0] base_t;

  typedef struct packed {
    base_t [READ_LEN-1:0] rd;
    base_t [HAP_LEN-1:0]  hp;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/test_pkt_if.sv
// Packet handshake between the sequencer and the compute core.
interface test_pkt_if;
  import test_pkt_pkg::*;

  logic pkt_vld;
  logic pkt_rdy;
  pkt_t pkt_dat;

  modport master (output pkt_vld, output pkt_dat, input pkt_rdy);
  modport slave  (input pkt_vld, input pkt_dat, output pkt_rdy);
endinterface

// File: rtl/test_pkt_matrix.sv
// 6-PE anti-diagonal scorer: 13 CALC cycles + 1 DONE cycle, sum_vld pulses in DONE.
// Accepts a packet only in IDLE (pkt_rdy), giving one packet every 15 cycles.
module matrix_6
  import test_pkt_pkg::*;
#(
  parameter int MATCH_W = DEF_MATCH_W
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  test_pkt_if.slave   pkt,
  output logic [63:0] sum,
  output logic        sum_vld
);
  localparam int VW = 16;
  localparam int HW = $clog2(HAP_LEN);

  state_t        state, state_nxt;
  logic [3:0]    step;
  pkt_t          pkt_q;
  logic [63:0]   acc;
  logic          rdy;
  logic [VW-1:0] cur [READ_LEN];
  logic [VW-1:0] prv [READ_LEN];
  logic [VW-1:0] nb  [READ_LEN];
  logic [VW-1:0] val [READ_LEN];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pkt.pkt_vld) state_nxt = CALC;
      CALC:    if (step == 4'(CALC_LEN - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy     = (state == IDLE);
    sum_vld = (state == DONE);
  end

  assign pkt.pkt_rdy = rdy;

  // Diagonal neighbour D[i-1][j-1] was produced by PE i-1 two steps ago
  always_comb begin
    nb[0] = '0;
    for (int i = 1; i < READ_LEN; i++) nb[i] = prv[i-1];
  end

  always_comb begin
    int j;
    j = 0;
    for (int i = 0; i < READ_LEN; i++) begin
      j      = int'(step) - i;
      val[i] = '0;
      if (j >= 0 && j < HAP_LEN) begin
        val[i] = nb[i];
        if (pkt_q.rd[i] == pkt_q.hp[HW'(j)]) val[i] = nb[i] + VW'(MATCH_W);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_q <= '0;
      step  <= '0;
      acc   <= '0;
      sum   <= '0;
      for (int i = 0; i < READ_LEN; i++) begin
        cur[i] <= '0;
        prv[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (pkt.pkt_vld) begin
          pkt_q <= pkt.pkt_dat;
          step  <= '0;
          acc   <= '0;
          for (int i = 0; i < READ_LEN; i++) begin
            cur[i] <= '0;
            prv[i] <= '0;
          end
        end
        CALC: begin
          step <= step + 4'd1;
          for (int i = 0; i < READ_LEN; i++) begin
            prv[i] <= cur[i];
            cur[i] <= val[i];
          end
          // Last row is zero outside its active steps, so it can be summed every step
          acc <= acc + 64'(val[READ_LEN-1]);
          if (step == 4'(CALC_LEN - 1)) sum <= acc + 64'(val[READ_LEN-1]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/test_pkt_seq.sv
// Packet sequencer: init window, then back-to-back packets; holds the packet until pkt_rdy.
// Latency: next packet is registered on the transfer edge, so pkt_vld never drops after init.
module pkt_seq
  import test_pkt_pkg::*;
#(
  parameter int          INIT_CYCLES  = 16,
  parameter int          PATTERN_MODE = 0,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  test_pkt_if.master pkt
);
  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  logic [CNT_W-1:0] init_cnt;
  logic             init;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_adv;
  logic [63:0]      read_cnt;
  logic             pkt_vld_q;
  pkt_t             pkt_dat_q;
  pkt_t             pkt_next;
  logic             load;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      init     <= 1'b1;
      init_cnt <= '0;
    end else if (init) begin
      if (init_cnt == CNT_W'(INIT_CYCLES - 1)) init <= 1'b0;
      else                                     init_cnt <= init_cnt + 1'b1;
    end
  end

  // Each base takes the current LFSR low bits, then the LFSR steps once
  always_comb begin
    logic [15:0] s;
    s        = lfsr;
    pkt_next = '0;
    for (int i = 0; i < READ_LEN; i++) begin
      pkt_next.rd[i] = s[1:0];
      s = lfsr_next(s);
    end
    for (int j = 0; j < HAP_LEN; j++) begin
      pkt_next.hp[j] = s[1:0];
      s = lfsr_next(s);
    end
    lfsr_adv = s;
    if (PATTERN_MODE == 1) begin
      pkt_next = '0;
    end else if (PATTERN_MODE == 2) begin
      pkt_next.rd = '0;
      pkt_next.hp = {HAP_LEN{2'b01}};
    end
  end

  assign load = !init && (!pkt_vld_q || pkt.pkt_rdy);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr      <= SEED;
      pkt_vld_q <= 1'b0;
      pkt_dat_q <= '0;
      read_cnt  <= '0;
    end else begin
      if (pkt_vld_q && pkt.pkt_rdy) read_cnt <= read_cnt + 64'd1;
      if (load) begin
        lfsr      <= lfsr_adv;
        pkt_dat_q <= pkt_next;
        pkt_vld_q <= 1'b1;
      end
    end
  end

  assign pkt.pkt_vld = pkt_vld_q;
  assign pkt.pkt_dat = pkt_dat_q;

endmodule

// File: rtl/test_pkt_top.sv
// Standalone harness: sequencer -> 6-PE core -> result FIFO drained one entry per cycle.
// result_fifo_rdat updates the cycle after a push into an empty FIFO; full pushes are dropped.
module test_pkt_top
  import test_pkt_pkg::*;
#(
  parameter int          MATCH_W      = DEF_MATCH_W,
  parameter int          INIT_CYCLES  = 16,
  parameter int          PATTERN_MODE = 0,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [63:0] result_fifo_rdat
);
  localparam int AW = $clog2(FIFO_DEPTH);

  test_pkt_if pkt_bus ();

  logic [63:0] sum;
  logic        sum_vld;

  pkt_seq #(
    .INIT_CYCLES (INIT_CYCLES),
    .PATTERN_MODE(PATTERN_MODE),
    .SEED        (SEED)
  ) s0 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pkt      (pkt_bus.master)
  );

  matrix_6 #(.MATCH_W(MATCH_W)) m0 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pkt      (pkt_bus.slave),
    .sum      (sum),
    .sum_vld  (sum_vld)
  );

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          full, empty, push, pop;

  assign full  = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign push  = sum_vld && !full;
  assign pop   = !empty;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      wptr             <= '0;
      rptr             <= '0;
      cnt              <= '0;
      ovf              <= 1'b0;
      result_fifo_rdat <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= sum;
        wptr      <= (wptr == AW'(FIFO_DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        result_fifo_rdat <= mem[rptr];
        rptr             <= (rptr == AW'(FIFO_DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (sum_vld && full) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_test_pkt_top.sv
// Directed bench: four harness instances in lockstep (LFSR, all-match W=1, no-match, all-match W=3).
module tb_test_pkt_top;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] rdat_lfsr, rdat_m1, rdat_m2, rdat_m3;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  logic [63:0] first_clean_sum;

  always #5 sys_clk = ~sys_clk;

  test_pkt_top #(.PATTERN_MODE(0)) u_lfsr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .result_fifo_rdat(rdat_lfsr));
  test_pkt_top #(.PATTERN_MODE(1), .MATCH_W(1)) u_m1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .result_fifo_rdat(rdat_m1));
  test_pkt_top #(.PATTERN_MODE(2)) u_m2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .result_fifo_rdat(rdat_m2));
  test_pkt_top #(.PATTERN_MODE(1), .MATCH_W(3)) u_m3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .result_fifo_rdat(rdat_m3));

  test_pkt_if mon ();
  assign mon.pkt_vld = u_m1.pkt_bus.pkt_vld;
  assign mon.pkt_rdy = u_m1.pkt_bus.pkt_rdy;
  assign mon.pkt_dat = u_m1.pkt_bus.pkt_dat;

  // Golden model: full DP matrix over the next packet drawn from the model LFSR
  task automatic model_pkt(output logic [63:0] s);
    logic [1:0] rb [6];
    logic [1:0] hb [8];
    int         d [6][8];
    for (int i = 0; i < 6; i++) begin
      rb[i]  = m_lfsr[1:0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    for (int j = 0; j < 8; j++) begin
      hb[j]  = m_lfsr[1:0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    s = 64'd0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 8; j++)
        d[i][j] = ((i > 0 && j > 0) ? d[i-1][j-1] : 0) + ((rb[i] == hb[j]) ? 1 : 0);
    for (int j = 0; j < 8; j++) s = s + 64'(d[5][j]);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    m_lfsr    = 16'hACE1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_hs(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 300 && !ok) begin
      @(negedge sys_clk);
      cyc++;
      if (mon.pkt_vld && mon.pkt_rdy) ok = 1'b1;
    end
  endtask

  task automatic wait_vld(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 300 && !ok) begin
      @(negedge sys_clk);
      cyc++;
      if (u_m1.m0.sum_vld) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    sys_rst_n = 1'b0;
    m_lfsr    = 16'hACE1;
    #31;
    n_cmp++; if (u_m1.s0.init !== 1'b1) begin n_err++; $display("FAIL rst_init got %b want 1", u_m1.s0.init); end
    n_cmp++; if (u_m1.s0.read_cnt !== 64'd0) begin n_err++; $display("FAIL rst_read_cnt got %0d want 0", u_m1.s0.read_cnt); end
    n_cmp++; if (u_m1.m0.sum !== 64'd0 || u_m1.m0.sum_vld !== 1'b0) begin n_err++; $display("FAIL rst_sum got %0d/%b want 0/0", u_m1.m0.sum, u_m1.m0.sum_vld); end
    n_cmp++; if ((rdat_lfsr | rdat_m1 | rdat_m2 | rdat_m3) !== 64'd0) begin n_err++; $display("FAIL rst_rdat got %h want 0", rdat_m1); end
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge sys_clk); #1;
      if (u_m1.m0.sum_vld) seen = 1'b1;
    end
    n_cmp++; if (u_m1.s0.init !== 1'b1) begin n_err++; $display("FAIL init_15 got %b want 1", u_m1.s0.init); end
    @(posedge sys_clk); #1;
    n_cmp++; if (u_m1.s0.init !== 1'b0) begin n_err++; $display("FAIL init_16 got %b want 0", u_m1.s0.init); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL init_sum_vld got %b want 0", seen); end
    n_cmp++; if (u_m1.s0.read_cnt !== 64'd0) begin n_err++; $display("FAIL init_read_cnt got %0d want 0", u_m1.s0.read_cnt); end
  endtask

  task automatic test_first_packet();
    int          c;
    bit          ok;
    logic [63:0] exp_s;
    wait_hs(c, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL first_hs timeout got %0d cycles want handshake", c); end
    wait_vld(c, ok);
    n_cmp++; if (!ok || c != 14) begin n_err++; $display("FAIL first_latency got %0d want 14", c); end
    model_pkt(exp_s);
    first_clean_sum = exp_s;
    n_cmp++; if (u_m1.m0.sum !== 64'd33) begin n_err++; $display("FAIL first_sum_w1 got %0d want 33", u_m1.m0.sum); end
    n_cmp++; if (u_m3.m0.sum !== 64'd99) begin n_err++; $display("FAIL first_sum_w3 got %0d want 99", u_m3.m0.sum); end
    n_cmp++; if (u_m2.m0.sum !== 64'd0) begin n_err++; $display("FAIL first_sum_nomatch got %0d want 0", u_m2.m0.sum); end
    n_cmp++; if (u_lfsr.m0.sum !== exp_s) begin n_err++; $display("FAIL first_sum_lfsr got %0d want %0d", u_lfsr.m0.sum, exp_s); end
    n_cmp++; if (u_m2.s0.read_cnt !== 64'd1) begin n_err++; $display("FAIL first_read_cnt got %0d want 1", u_m2.s0.read_cnt); end
    @(negedge sys_clk);
    n_cmp++; if (u_m1.m0.sum_vld !== 1'b0) begin n_err++; $display("FAIL vld_width got %b want 0", u_m1.m0.sum_vld); end
    n_cmp++; if (u_m1.m0.sum !== 64'd33) begin n_err++; $display("FAIL sum_hold got %0d want 33", u_m1.m0.sum); end
    @(negedge sys_clk);
    n_cmp++; if (rdat_m1 !== 64'h21) begin n_err++; $display("FAIL rdat_w1 got %h want 21", rdat_m1); end
    n_cmp++; if (rdat_m3 !== 64'h63) begin n_err++; $display("FAIL rdat_w3 got %h want 63", rdat_m3); end
    n_cmp++; if (rdat_lfsr !== exp_s) begin n_err++; $display("FAIL rdat_lfsr got %h want %h", rdat_lfsr, exp_s); end
  endtask

  // 20 more packets: steady 15-cycle cadence, read_cnt steps, FIFO pointers wrap past 16
  task automatic test_back_to_back();
    int          c;
    bit          ok;
    logic [63:0] exp_s;
    for (int p = 2; p <= 21; p++) begin
      wait_vld(c, ok);
      n_cmp++; if (!ok || c + 2 != 15) begin n_err++; $display("FAIL b2b_interval pkt %0d got %0d want 15", p, c + 2); end
      model_pkt(exp_s);
      n_cmp++; if (u_lfsr.m0.sum !== exp_s) begin n_err++; $display("FAIL b2b_sum_lfsr pkt %0d got %0d want %0d", p, u_lfsr.m0.sum, exp_s); end
      n_cmp++; if (u_m1.m0.sum !== 64'd33 || u_m3.m0.sum !== 64'd99 || u_m2.m0.sum !== 64'd0) begin
        n_err++; $display("FAIL b2b_sum_fixed pkt %0d got %0d/%0d/%0d want 33/99/0", p, u_m1.m0.sum, u_m3.m0.sum, u_m2.m0.sum);
      end
      n_cmp++; if (u_m2.s0.read_cnt !== 64'(p)) begin n_err++; $display("FAIL b2b_read_cnt got %0d want %0d", u_m2.s0.read_cnt, p); end
      @(negedge sys_clk);
      @(negedge sys_clk);
      n_cmp++; if (rdat_lfsr !== exp_s) begin n_err++; $display("FAIL b2b_rdat pkt %0d got %h want %h", p, rdat_lfsr, exp_s); end
    end
  endtask

  task automatic test_reset_mid_calc();
    int          c;
    bit          ok;
    bit          seen;
    logic [63:0] exp_s;
    apply_reset();
    wait_hs(c, ok);
    wait_vld(c, ok);
    wait_hs(c, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_hs timeout got %0d cycles want handshake", c); end
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    m_lfsr    = 16'hACE1;
    #1;
    n_cmp++; if (u_m1.m0.sum !== 64'd0 || rdat_m1 !== 64'd0) begin n_err++; $display("FAIL abort_clear got %0d/%0d want 0/0", u_m1.m0.sum, rdat_m1); end
    n_cmp++; if (u_m1.s0.read_cnt !== 64'd0 || u_m1.s0.init !== 1'b1) begin n_err++; $display("FAIL abort_seq got %0d/%b want 0/1", u_m1.s0.read_cnt, u_m1.s0.init); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = 1'b0;
    c    = 0;
    ok   = 1'b0;
    while (c < 300 && !ok) begin
      @(negedge sys_clk);
      c++;
      if (u_m1.m0.sum_vld) seen = 1'b1;
      if (mon.pkt_vld && mon.pkt_rdy) ok = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0 || !ok) begin n_err++; $display("FAIL abort_no_vld got vld=%b hs=%b want 0/1", seen, ok); end
    wait_vld(c, ok);
    n_cmp++; if (!ok || c != 14) begin n_err++; $display("FAIL abort_latency got %0d want 14", c); end
    model_pkt(exp_s);
    n_cmp++; if (u_lfsr.m0.sum !== first_clean_sum || u_lfsr.m0.sum !== exp_s) begin
      n_err++; $display("FAIL abort_first_sum got %0d want %0d", u_lfsr.m0.sum, first_clean_sum);
    end
    n_cmp++; if (u_lfsr.s0.read_cnt !== 64'd1) begin n_err++; $display("FAIL abort_read_cnt got %0d want 1", u_lfsr.s0.read_cnt); end
  endtask

  // 1500 edges after release: transfers at edges 18, 33, ... -> 99 packets
  task automatic test_long_run();
    apply_reset();
    repeat (1500) @(posedge sys_clk);
    #1;
    n_cmp++; if (u_lfsr.s0.read_cnt < 64'd98 || u_lfsr.s0.read_cnt > 64'd100) begin
      n_err++; $display("FAIL long_read_cnt got %0d want 99+-1", u_lfsr.s0.read_cnt);
    end
    n_cmp++; if (u_lfsr.ovf !== 1'b0) begin n_err++; $display("FAIL long_ovf got %b want 0", u_lfsr.ovf); end
  endtask

  initial begin
    test_reset();
    test_first_packet();
    test_back_to_back();
    test_reset_mid_calc();
    test_long_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/test_pkt_top.md
Name: test_pkt_top

Overview:
- Self-contained packet test harness for the 6-PE PairHMM diagonal matrix.
- An internal sequencer (instance s0) generates read/haplotype packets.
- A 6-PE anti-diagonal compute core (instance m0) scores each packet and produces a 64-bit sum.
- Sums go into a result FIFO that drains continuously to an output port. The top level has no data inputs; it runs standalone after reset.

Parameters:
- READ_LEN, 6: read bases per packet; equals the PE count.
- HAP_LEN, 8: haplotype bases per packet.
- MATCH_W, 1: score added on a base match.
- INIT_CYCLES, 16: cycles that s0.init stays high after reset release.
- PATTERN_MODE, 0: stimulus source. 0 = LFSR, 1 = all bases 2'b00, 2 = read bases 2'b00 with haplotype bases 2'b01.
- SEED, 16'hACE1: LFSR seed.
- FIFO_DEPTH, 16: result FIFO entries.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active low.
- result_fifo_rdat  out  64  last sum popped from the result FIFO.

Behaviour:
- Reset: all registers clear; result_fifo_rdat = 0; m0.sum = 0; m0.sum_vld = 0; s0.init = 1; s0.read_cnt = 0; LFSR = SEED; FIFO empty. Reset asserted mid-packet aborts the packet; no sum is produced.
- Sequencer s0, init phase: s0.init is held at 1 for INIT_CYCLES cycles after reset release, then drops to 0 permanently.
- Sequencer s0, packet build: once init = 0, s0 presents one packet = READ_LEN x 2-bit read bases plus HAP_LEN x 2-bit haplotype bases, with pkt_vld.
- LFSR mode: 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances once per generated base; each base takes the LFSR low 2 bits. Read bases are drawn first, then haplotype bases.
- Handshake: a packet transfers when pkt_vld && pkt_rdy. s0.read_cnt (64-bit) increments by 1 on each transfer and wraps at 2^64.
- Compute core m0, states: IDLE -> CALC -> DONE -> IDLE.
  - pkt_rdy = 1 only in IDLE.
  - CALC lasts READ_LEN+HAP_LEN-1 = 13 cycles, one anti-diagonal per cycle.
  - DONE lasts 1 cycle, then returns to IDLE.
- Cell recurrence: D[i][j] = D[i-1][j-1] + (read[i]==hap[j] ? MATCH_W : 0). Out-of-range neighbours are 0. PE i owns row i and keeps its previous-diagonal value in a register.
- Sum: sum = sum over j of D[READ_LEN-1][j], accumulated at 64-bit width with no saturation.
- Output timing: m0.sum is registered. m0.sum_vld pulses high for exactly 1 cycle in DONE, with sum valid in that same cycle. m0.sum holds its value until the next DONE.
- Throughput: 15 cycles per packet, i.e. handshake to the next handshake.
- Result FIFO: push when m0.sum_vld is high. An internal reader pops whenever the FIFO is non-empty, one entry per cycle, and registers the popped value into result_fifo_rdat. result_fifo_rdat changes one cycle after a push into an empty FIFO and otherwise holds.
- FIFO full: if full at push time, the push is dropped and a sticky internal ovf flag is set. This cannot occur with the continuous drain.
- FIFO wrap: read and write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package test_pkt_pkg: base_t (2-bit); the READ_LEN, HAP_LEN and MATCH_W defaults; the LFSR tap constant; and the m0 state enum (IDLE, CALC, DONE).
- Natural sub-modules:
  - pkt_seq (instance s0): init counter, LFSR, read_cnt.
  - matrix_6 (instance m0): 6 PEs, sum, sum_vld.
- The FIFO stays in the top level.
- Hierarchical names test_pkt_top.m0.sum, m0.sum_vld, s0.init and s0.read_cnt must exist for bench monitors.

Test Plan:
- Reset held 31 ns, then released -> s0.init = 1 for 16 cycles; s0.read_cnt = 0; result_fifo_rdat = 0; sum_vld stays 0 during init.
- PATTERN_MODE=1, MATCH_W=1 -> every sum = 33 (0x...0021). sum_vld pulses every 15 cycles, first pulse 14 cycles after the first handshake. result_fifo_rdat = 0x21 one cycle later.
- PATTERN_MODE=2 -> every sum = 0; read_cnt increments 1, 2, 3, ... once per packet.
- PATTERN_MODE=1, MATCH_W=3 -> sum = 99 (0x63).
- PATTERN_MODE=0, SEED=16'hACE1 -> sums match a golden software model of the same LFSR and recurrence. Run 600000 cycles; read_cnt ends at floor((600000-INIT_CYCLES-offset)/15) ± 1.
- Assert reset mid-CALC, then release -> no sum_vld for the aborted packet; read_cnt restarts from 0; the first sum after init equals the first sum of a clean run.
